// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC job sequencer: default widths, FSM encoding and
// the job record width helper.
package ecc_pkg;

  localparam int unsigned FIELD_WIDTH_DEF  = 16;
  localparam int unsigned SCALAR_WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF        = 4;
  localparam int unsigned TAG_WIDTH_DEF    = 4;
  localparam int unsigned TIMEOUT_DEF      = 1023;

  localparam int unsigned JOB_W_DEF = 2 * FIELD_WIDTH_DEF + SCALAR_WIDTH_DEF + TAG_WIDTH_DEF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  // Job record = {x, y, scalar, tag}
  function automatic int unsigned job_w(input int unsigned fw, input int unsigned sw,
                                        input int unsigned tw);
    return 2 * fw + sw + tw;
  endfunction

endpackage

// File: rtl/ecc_job_fifo.sv
// Job FIFO: register-array storage with async-reset pointers and occupancy count;
// head entry is visible on rdata_o whenever the FIFO is not empty.
module ecc_job_fifo
  import ecc_pkg::*;
#(
  parameter int unsigned  WIDTH = JOB_W_DEF,
  parameter int unsigned  DEPTH = DEPTH_DEF,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ecc_job_sequencer.sv
// Queues scalar-multiplication jobs, issues them one at a time to the ECC core,
// and returns tagged results (or a timeout error) on a valid/ready channel.
module ecc_job_sequencer
  import ecc_pkg::*;
#(
  parameter int unsigned FIELD_WIDTH  = FIELD_WIDTH_DEF,
  parameter int unsigned SCALAR_WIDTH = SCALAR_WIDTH_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned TAG_WIDTH    = TAG_WIDTH_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [FIELD_WIDTH-1:0]  req_x,
  input  logic [FIELD_WIDTH-1:0]  req_y,
  input  logic [SCALAR_WIDTH-1:0] req_scalar,
  output logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    ecc_start,
  output logic [FIELD_WIDTH-1:0]  point_x,
  output logic [FIELD_WIDTH-1:0]  point_y,
  output logic [SCALAR_WIDTH-1:0] scalar,
  input  logic                    ecc_done,
  input  logic [FIELD_WIDTH-1:0]  result_x,
  input  logic [FIELD_WIDTH-1:0]  result_y,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FIELD_WIDTH-1:0]  rsp_x,
  output logic [FIELD_WIDTH-1:0]  rsp_y,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int unsigned JOB_W = job_w(FIELD_WIDTH, SCALAR_WIDTH, TAG_WIDTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [FIELD_WIDTH-1:0]  px_q, px_d, py_q, py_d;
  logic [SCALAR_WIDTH-1:0] sc_q, sc_d;
  logic [TAG_WIDTH-1:0]    cur_tag_q, cur_tag_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    start_q, start_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [FIELD_WIDTH-1:0]  rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
  logic [TAG_WIDTH-1:0]    rsp_tag_q, rsp_tag_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    after_to_q, after_to_d;
  logic                    idle_seen_q, idle_seen_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [JOB_W-1:0]        fifo_wdata, fifo_rdata;
  logic [FIELD_WIDTH-1:0]  head_x, head_y;
  logic [SCALAR_WIDTH-1:0] head_sc;
  logic [TAG_WIDTH-1:0]    head_tag;

  assign fifo_push  = req_valid && !fifo_full;
  assign fifo_wdata = {req_x, req_y, req_scalar, tag_q};

  ecc_job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_x   = fifo_rdata[JOB_W-1 -: FIELD_WIDTH];
  assign head_y   = fifo_rdata[JOB_W-FIELD_WIDTH-1 -: FIELD_WIDTH];
  assign head_sc  = fifo_rdata[TAG_WIDTH +: SCALAR_WIDTH];
  assign head_tag = fifo_rdata[0 +: TAG_WIDTH];

  always_comb begin
    state_d     = state_q;
    tag_d       = fifo_push ? tag_q + TAG_WIDTH'(1) : tag_q;
    px_d        = px_q;
    py_d        = py_q;
    sc_d        = sc_q;
    cur_tag_d   = cur_tag_q;
    wd_d        = wd_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_x_d     = rsp_x_q;
    rsp_y_d     = rsp_y_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    after_to_d  = after_to_q;
    idle_seen_d = (state_q == ST_IDLE);
    fifo_pop    = 1'b0;

    unique case (state_q)
      // After a timeout, hold off one extra IDLE cycle so the core can settle.
      ST_IDLE: begin
        if (!fifo_empty && (!after_to_q || idle_seen_q)) begin
          fifo_pop   = 1'b1;
          px_d       = head_x;
          py_d       = head_y;
          sc_d       = head_sc;
          cur_tag_d  = head_tag;
          start_d    = 1'b1;
          after_to_d = 1'b0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_d = wd_q + WD_W'(1);
        if (ecc_done) begin
          state_d = ST_CAPTURE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          rsp_x_d     = '0;
          rsp_y_d     = '0;
          rsp_tag_d   = cur_tag_q;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          after_to_d  = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_CAPTURE: begin
        rsp_x_d     = result_x;
        rsp_y_d     = result_y;
        rsp_tag_d   = cur_tag_q;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tag_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      sc_q        <= '0;
      cur_tag_q   <= '0;
      wd_q        <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      after_to_q  <= 1'b0;
      idle_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      px_q        <= px_d;
      py_q        <= py_d;
      sc_q        <= sc_d;
      cur_tag_q   <= cur_tag_d;
      wd_q        <= wd_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_x_q     <= rsp_x_d;
      rsp_y_q     <= rsp_y_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
      after_to_q  <= after_to_d;
      idle_seen_q <= idle_seen_d;
    end
  end

  assign req_ready = !fifo_full;
  assign req_tag   = tag_q;
  assign ecc_start = start_q;
  assign point_x   = px_q;
  assign point_y   = py_q;
  assign scalar    = sc_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_ecc_job_sequencer.sv
// Scoreboard bench for ecc_job_sequencer: directed jobs, a behavioural ECC core,
// and a response monitor checking data, tag order, error flag and latency.
module tb_ecc_job_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_x = '0, req_y = '0, req_scalar = '0;
  logic [3:0]  req_tag;
  logic        ecc_start;
  logic [15:0] point_x, point_y, scalar;
  logic        ecc_done = 1'b0;
  logic [15:0] result_x = '0, result_y = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_x, rsp_y;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;

  ecc_job_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_scalar(req_scalar), .req_tag(req_tag),
    .ecc_start(ecc_start), .point_x(point_x), .point_y(point_y), .scalar(scalar),
    .ecc_done(ecc_done), .result_x(result_x), .result_y(result_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  tag;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] tb_tag = '0;

  // Core model state
  int          core_delay = 6;
  bit          core_hang = 1'b0;
  bit          spurious = 1'b0;
  int          start_cnt = 0;
  int          last_start_cyc = 0;
  logic [15:0] start_px = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural core: result = point + constant, done core_delay cycles after start.
  initial begin : core_model
    bit          pend;
    int          done_cyc;
    logic [15:0] px, py;
    pend = 1'b0; done_cyc = 0; px = '0; py = '0;
    forever begin
      @(posedge clk); #1;
      ecc_done = 1'b0;
      if (rst) pend = 1'b0;
      if (spurious) begin
        ecc_done = 1'b1;
        spurious = 1'b0;
      end
      if (pend && cyc == done_cyc) begin
        ecc_done = 1'b1;
        result_x = 16'(px + 16'h1231);
        result_y = 16'(py + 16'h5673);
        pend     = 1'b0;
      end
      if (ecc_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        px = point_x;
        py = point_y;
        start_px = point_x;
        if (!core_hang) begin
          pend     = 1'b1;
          done_cyc = cyc + core_delay;
        end
      end
    end
  end

  // Response monitor: latency on rsp_valid rise, payload on handshake.
  initial begin : monitor
    bit   prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (rsp_valid && !prev_v) begin
          if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
          else check("rsp_latency", cyc - last_start_cyc, exp_q[0].lat);
        end
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_x", rsp_x, e.x);
          check("rsp_y", rsp_y, e.y);
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_err", rsp_err, e.err);
        end
        prev_v = rsp_valid;
      end
    end
  end

  task automatic push_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] s,
                          input bit to, output logic [3:0] tag_seen, output int waited);
    exp_t e;
    req_x = x; req_y = y; req_scalar = s; req_valid = 1'b1;
    waited = 0;
    tag_seen = '0;
    @(negedge clk);
    while (!req_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("push_timeout", 0, 1);
    end else begin
      tag_seen = req_tag;
      check("req_tag", req_tag, tb_tag);
      e.x   = to ? 16'h0 : 16'(x + 16'h1231);
      e.y   = to ? 16'h0 : 16'(y + 16'h5673);
      e.tag = tb_tag;
      e.err = to;
      e.lat = to ? 16 : core_delay + 2;
      exp_q.push_back(e);
      tb_tag = tb_tag + 4'd1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    tb_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ecc_start", ecc_start, 0);
    check("rst_req_tag", req_tag, 0);
    check("rst_point_x", point_x, 0);
    rst = 1'b0;
  endtask

  initial begin : stimulus
    logic [3:0]  tg;
    int          w;
    int          sc;
    logic [48:0] held;
    int          n;

    do_reset();

    // 1: single job
    core_delay = 6; rsp_ready = 1'b1;
    sc = start_cnt;
    push_job(16'h0003, 16'h0005, 16'h0001, 1'b0, tg, w);
    wait_drain(100);
    check("t1_start_count", start_cnt - sc, 1);
    check("t1_point_x", start_px, 16'h0003);

    // 2: fill and backpressure
    core_delay = 10; rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_job(16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0001, 1'b0, tg, w);
    @(negedge clk);
    check("t2_req_ready_full", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain(400);

    // 3: tag wrap over 18 jobs
    do_reset();
    core_delay = 2;
    for (int i = 0; i < 18; i++) begin
      push_job(16'(i * 7), 16'hA000 ^ 16'(i), 16'h0003, 1'b0, tg, w);
      if (i == 16) check("t3_tag17_wrap", tg, 0);
    end
    wait_drain(1000);

    // 4: timeout, spurious done, recovery
    core_hang = 1'b1; core_delay = 6;
    push_job(16'h0042, 16'h0043, 16'h0044, 1'b1, tg, w);
    wait_drain(200);
    core_hang = 1'b0;
    sc = start_cnt;
    spurious = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t4_spurious_start", start_cnt, sc);
    check("t4_spurious_busy", busy, 0);
    check("t4_spurious_rsp", rsp_valid, 0);
    push_job(16'h0777, 16'h0888, 16'h0009, 1'b0, tg, w);
    wait_drain(200);

    // 5: held response
    rsp_ready = 1'b0;
    push_job(16'h1000, 16'h2000, 16'h0005, 1'b0, tg, w);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_rsp_valid", rsp_valid, 1);
    held = {rsp_x, rsp_y, rsp_tag, rsp_err, rsp_valid, 11'h0};
    sc = start_cnt;
    @(posedge clk); #1;
    push_job(16'h3000, 16'h4000, 16'h0006, 1'b0, tg, w);
    check("t5_push_wait", w, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_rsp_stable", int'({rsp_x, rsp_y} != held[48:17] || rsp_tag != held[16:13]
                                   || rsp_err != held[12] || !rsp_valid), 0);
    end
    check("t5_no_start", start_cnt, sc);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain(200);

    // 6: reset mid-WAIT_DONE with jobs queued
    core_hang = 1'b1;
    sc = start_cnt;
    for (int i = 0; i < 4; i++)
      push_job(16'h0500 + 16'(i), 16'h0600, 16'h0001, 1'b1, tg, w);
    n = 0;
    while (start_cnt == sc && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_started", start_cnt - sc, 1);
    @(posedge clk); #1;
    check("t6_busy_before", busy, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_req_ready", req_ready, 1);
    check("t6_busy", busy, 0);
    check("t6_ecc_start", ecc_start, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_point_x", point_x, 0);
    check("t6_req_tag", req_tag, 0);
    exp_q.delete();
    tb_tag = '0;
    core_hang = 1'b0;
    sc = start_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t6_no_start", start_cnt, sc);
    check("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
